// File: rtl/psx_pad_emulator.sv
// PSX controller emulator: oversamples the console's psx_clk/att/cmd lines in the system clock
// domain, answers 0x42 polls in digital or analog format, captures motor bytes and paces acks.
module psx_pad_emulator #(
   parameter int         SYNC_STAGES = 2,
   parameter int         ACK_DELAY   = 8,
   parameter int         ACK_WIDTH   = 4,
   parameter bit         ANALOG_EN   = 1'b1,
   parameter logic [7:0] DIGITAL_ID  = 8'h41,
   parameter logic [7:0] ANALOG_ID   = 8'h73
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        psx_clk,
   input  logic        att,
   input  logic        cmd,
   input  logic [15:0] buttons,
   input  logic [31:0] sticks,
   input  logic        analog_mode,
   output logic        data,
   output logic        ack,
   output logic [15:0] motor,
   output logic        motor_valid,
   output logic        busy
);

   localparam int CNT_MAX = (ACK_DELAY > ACK_WIDTH) ? ACK_DELAY : ACK_WIDTH;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SHIFT, S_ACK_WAIT, S_ACK_PULSE, S_DONE, S_ABORT
   } state_t;

   state_t                   r_state;
   logic [SYNC_STAGES-1:0]   r_clk_sync, r_att_sync, r_cmd_sync;
   logic [15:0]              r_btn;
   logic [31:0]              r_stk;
   logic                     r_mode;
   logic [3:0]               r_byte_cnt;
   logic [2:0]               r_bit_cnt;
   logic [6:0]               r_rx;
   logic [15:0]              r_motor_stg;
   logic [CNT_W-1:0]         r_cnt;
   logic                     r_ack_pend;
   logic                     r_data, r_ack, r_motor_valid, r_busy;
   logic [15:0]              r_motor;

   logic       w_fall, w_rise, w_att_fall, w_att_rise, w_cmd;
   logic [7:0] w_tx_byte, w_rx_byte;
   logic       w_last, w_bad_cmd, w_pulse_end;

   // Edges are judged on the two oldest synchroniser stages; cmd is taken one stage later
   // so it is settled well before the rising edge that samples it.
   assign w_fall     =  r_clk_sync[SYNC_STAGES-1] & ~r_clk_sync[SYNC_STAGES-2];
   assign w_rise     = ~r_clk_sync[SYNC_STAGES-1] &  r_clk_sync[SYNC_STAGES-2];
   assign w_att_fall =  r_att_sync[SYNC_STAGES-1] & ~r_att_sync[SYNC_STAGES-2];
   assign w_att_rise = ~r_att_sync[SYNC_STAGES-1] &  r_att_sync[SYNC_STAGES-2];
   assign w_cmd      =  r_cmd_sync[SYNC_STAGES-1];

   assign w_rx_byte   = {w_cmd, r_rx};
   assign w_last      = (r_byte_cnt == (r_mode ? 4'd8 : 4'd4));
   assign w_bad_cmd   = ((r_byte_cnt == 4'd0) && (w_rx_byte != 8'h01)) ||
                        ((r_byte_cnt == 4'd1) && (w_rx_byte != 8'h42));
   assign w_pulse_end = (r_state == S_ACK_PULSE) && (r_cnt == CNT_W'(ACK_WIDTH - 1));

   always_comb begin
      w_tx_byte = 8'hFF;
      case (r_byte_cnt)
         4'd1:    w_tx_byte = r_mode ? ANALOG_ID : DIGITAL_ID;
         4'd2:    w_tx_byte = 8'h5A;
         4'd3:    w_tx_byte = r_btn[7:0];
         4'd4:    w_tx_byte = r_btn[15:8];
         4'd5:    w_tx_byte = r_stk[7:0];
         4'd6:    w_tx_byte = r_stk[15:8];
         4'd7:    w_tx_byte = r_stk[23:16];
         4'd8:    w_tx_byte = r_stk[31:24];
         default: w_tx_byte = 8'hFF;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_clk_sync    <= '1;
         r_att_sync    <= '1;
         r_cmd_sync    <= '1;
         r_state       <= S_IDLE;
         r_btn         <= '0;
         r_stk         <= '0;
         r_mode        <= 1'b0;
         r_byte_cnt    <= '0;
         r_bit_cnt     <= '0;
         r_rx          <= '0;
         r_motor_stg   <= '0;
         r_cnt         <= '0;
         r_ack_pend    <= 1'b0;
         r_data        <= 1'b1;
         r_ack         <= 1'b1;
         r_motor       <= '0;
         r_motor_valid <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_clk_sync    <= {r_clk_sync[SYNC_STAGES-2:0], psx_clk};
         r_att_sync    <= {r_att_sync[SYNC_STAGES-2:0], att};
         r_cmd_sync    <= {r_cmd_sync[SYNC_STAGES-2:0], cmd};
         r_motor_valid <= 1'b0;

         if (w_att_rise) begin
            r_state    <= S_IDLE;
            r_data     <= 1'b1;
            r_ack      <= 1'b1;
            r_busy     <= 1'b0;
            r_ack_pend <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_att_fall) begin
                     r_btn      <= buttons;
                     r_stk      <= sticks;
                     r_mode     <= analog_mode & ANALOG_EN;
                     r_byte_cnt <= '0;
                     r_bit_cnt  <= '0;
                     r_cnt      <= '0;
                     r_busy     <= 1'b1;
                     r_data     <= 1'b1;
                     r_state    <= S_SHIFT;
                  end
               end
               S_DONE, S_ABORT: begin
                  r_data <= 1'b1;
                  r_ack  <= 1'b1;
               end
               default: begin
                  // Ack pacing runs alongside shifting; a fast host is never held off.
                  if (r_state == S_ACK_WAIT) begin
                     if (r_cnt == CNT_W'(ACK_DELAY - 1)) begin
                        r_state <= S_ACK_PULSE;
                        r_ack   <= 1'b0;
                        r_cnt   <= '0;
                     end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                     end
                  end else if (r_state == S_ACK_PULSE) begin
                     if (w_pulse_end) begin
                        r_ack      <= 1'b1;
                        r_cnt      <= '0;
                        r_ack_pend <= 1'b0;
                        r_state    <= r_ack_pend ? S_ACK_WAIT : S_SHIFT;
                     end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                     end
                  end

                  if (w_fall)
                     r_data <= w_tx_byte[r_bit_cnt];

                  if (w_rise) begin
                     r_rx      <= {w_cmd, r_rx[6:1]};
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                     if (r_bit_cnt == 3'd7) begin
                        r_byte_cnt <= r_byte_cnt + 4'd1;
                        if (w_bad_cmd) begin
                           r_state    <= S_ABORT;
                           r_data     <= 1'b1;
                           r_ack      <= 1'b1;
                           r_ack_pend <= 1'b0;
                        end else if (w_last) begin
                           r_state       <= S_DONE;
                           r_data        <= 1'b1;
                           r_ack         <= 1'b1;
                           r_ack_pend    <= 1'b0;
                           r_motor       <= (r_byte_cnt == 4'd4) ?
                                            {w_rx_byte, r_motor_stg[7:0]} : r_motor_stg;
                           r_motor_valid <= 1'b1;
                        end else begin
                           if (r_byte_cnt == 4'd3) r_motor_stg[7:0]  <= w_rx_byte;
                           if (r_byte_cnt == 4'd4) r_motor_stg[15:8] <= w_rx_byte;
                           // A pulse still running finishes first, then the new wait starts.
                           if ((r_state == S_ACK_PULSE) && !w_pulse_end) begin
                              r_ack_pend <= 1'b1;
                           end else begin
                              r_state <= S_ACK_WAIT;
                              r_cnt   <= '0;
                              r_ack   <= 1'b1;
                           end
                        end
                     end
                  end
               end
            endcase
         end
      end
   end

   assign data        = r_data;
   assign ack         = r_ack;
   assign motor       = r_motor;
   assign motor_valid = r_motor_valid;
   assign busy        = r_busy;

endmodule

// File: doc/psx_pad_emulator.md
Name: psx_pad_emulator

Overview:
- Parametrised successor to the fixed-pattern pad model: a full PSX controller emulator in the system clock domain, oversampling the console's psx_clk/att/cmd lines.
- Answers 0x42 polls in digital (ID 0x41, 5 bytes) or analog (ID 0x73, 9 bytes) mode from live button/stick inputs.
- Decodes host command bytes, rejects foreign addresses and captures the host's motor bytes.
- Generates timed ack pulses per byte.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on psx_clk, att, cmd (min 2).
- ACK_DELAY, 8, clk cycles from byte end (8th sampling edge) to ack falling.
- ACK_WIDTH, 4, clk cycles ack held low (min 1).
- ANALOG_EN, 1, 0 forces digital mode regardless of analog_mode input.
- DIGITAL_ID, 8'h41, ID byte in digital mode.
- ANALOG_ID, 8'h73, ID byte in analog mode.

Ports:
- clk  in  1  system clock; oversamples the PSX bus.
- reset  in  1  synchronous, active-low reset.
- psx_clk  in  1  console serial clock (async); idle high.
- att  in  1  console attention (async), active-low frame select.
- cmd  in  1  console command bit (async), LSB first.
- buttons  in  16  active-low buttons: [7:0]=byte3, [15:8]=byte4 (Select..Left, L2..Square).
- sticks  in  32  RX,RY,LX,LY bytes [7:0],[15:8],[23:16],[31:24].
- analog_mode  in  1  request analog frame format.
- data  out  1  controller data bit to console; idle 1.
- ack  out  1  active-low acknowledge; idle 1.
- motor  out  16  last captured host bytes 3 (low) and 4 (high).
- motor_valid  out  1  one-clk strobe when motor updates.
- busy  out  1  frame in progress.

Behaviour:
- Reset (reset=0 at clk rise): data=1, ack=1, motor=0, motor_valid=0, busy=0, FSM=IDLE, all counters 0. This overrides any in-progress frame.
- Synchronise all three bus inputs through SYNC_STAGES flops. Edges are detected on the last two stages.
  - fall = falling edge of psx_clk; rise = rising edge of psx_clk.
- Every output is registered.
- On att falling edge (IDLE -> SHIFT):
  - Snapshot buttons and sticks.
  - Set mode = analog_mode & ANALOG_EN.
  - Load byte0 = 8'hFF; set busy=1, byte_cnt=0, bit_cnt=0.
  - Frame length N = 9 if mode else 5.
- Transmit byte table: byte0 FF; byte1 ID; byte2 5A; byte3 buttons[7:0]; byte4 buttons[15:8]; bytes5-8 sticks[7:0]..[31:24].
- SHIFT:
  - On fall: data <= current byte bit[bit_cnt], LSB first. Data updates exactly 1 clk after fall is detected.
  - On rise: shift sampled cmd into rx[bit_cnt]; bit_cnt++.
  - When bit_cnt wraps 7->0, the byte is complete and byte_cnt increments.
- Command checks at byte completion:
  - byte0 rx != 8'h01 -> ABORT.
  - byte1 rx != 8'h42 -> ABORT.
  - byte3 rx -> motor[7:0] (staged); byte4 rx -> motor[15:8] (staged).
- Ack sequencing:
  - After completing byte k with k < N-1 (and no abort), go to ACK_WAIT.
  - ACK_WAIT: count ACK_DELAY clks, then ACK_PULSE.
  - ACK_PULSE: ack=0 for ACK_WIDTH clks, then ack=1 and return to SHIFT.
  - The last byte is never acked.
- psx_clk edges during ACK_WAIT/ACK_PULSE are still honoured for shifting, so a host that does not wait for ack still receives data. The ack pulse is not cut short by a clock edge.
- After the last byte completes: FSM -> DONE, data=1.
  - If mode covered bytes 3-4, motor <= staged value and motor_valid pulses 1 clk.
  - Motor is also captured in digital mode, since byte4 exists there.
- ABORT/DONE: data=1, ack=1, ignore psx_clk until att rises.
- att rising edge, from any state: immediate return to IDLE next clk. Sets data=1, ack=1, busy=0.
  - Truncated frames never update motor or pulse motor_valid.
  - An ack in progress is terminated (ack=1).
- att falling edge while not IDLE: cannot occur without a preceding rise, because rise has priority.
- Simultaneous att rise and psx_clk edge in the same clk: att wins.
- Input changes mid-frame do not affect the transmitted frame (snapshot).

Test Plan:
- Digital poll: analog_mode=0, buttons=16'hFF7F, host sends 01 42 00 00 00 -> data bytes FF 41 5A 7F FF; 4 ack pulses, each starting ACK_DELAY=8 clks after byte end and lasting 4 clks; no ack after byte4; motor_valid=1 for 1 clk.
- Analog poll: analog_mode=1, sticks=32'h80807F81 -> FF 73 5A <buttons> 81 7F 80 80; 8 acks; busy low after att rises.
- ANALOG_EN=0 instance with analog_mode=1 -> ID 41, 5-byte frame.
- Foreign address: host byte0=02 -> data stays 1 after byte0, zero acks, motor unchanged.
- Bad command: byte1=43 -> ack after byte0 only; then silent until att rises.
- Abort and reset: att rises mid-byte3 -> data=1 and ack=1 within SYNC_STAGES+1 clks, motor_valid never fires; reset asserted mid-ACK_PULSE -> ack=1 and busy=0 on next clk; the next frame is normal.
- Snapshot: change buttons from FFFF to 0000 during byte2 -> bytes3-4 still FF FF.
